emif_bus_arbiter: RTL and testbench
===================================

Name: emif_bus_arbiter

Overview:
- Shares one single-port register RAM between two requesters: MCU EMIF writes and a local FPGA requester.
- MCU writes are marked by the active-low `we_logic` strobe; local access windows are gated by `mcu_idle`. Both signals come from the EMIF sync block.
- The MCU always has priority. A local burst is granted only after a guard interval inside an idle window, and is pre-empted when the MCU becomes active.

Parameters:
AW, 8, RAM address width
DW, 16, RAM data width
GUARD, 4, cycles mcu_idle and loc_req must stay high before grant (min 1)
LOC_MAX, 8, max local transfers per grant (min 1)

Ports:
clk  in  1  200MHz system clock
rst  in  1  synchronous active-high reset
we_logic  in  1  active-low MCU write strobe (6-cycle pulse)
mcu_idle  in  1  high = MCU bus idle
emif_addr  in  AW  MCU write address
emif_data  in  DW  MCU write data
loc_req  in  1  local request / transfer valid
loc_we  in  1  local access is a write
loc_addr  in  AW  local address
loc_wdata  in  DW  local write data
loc_gnt  out  1  local grant, high only in state LOC_ACC
loc_rdata  out  DW  read data (equals ram_rdata)
loc_rvalid  out  1  loc_rdata valid, one cycle
loc_done  out  1  one-cycle pulse, burst ended normally
loc_abort  out  1  one-cycle pulse, burst pre-empted
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, 1-cycle read latency
mcu_wr_cnt  out  16  MCU write count, wraps 0xFFFF->0
preempt_cnt  out  8  abort count, saturates at 0xFF

Behaviour:
- Single clock `clk`; reset `rst` is synchronous, active-high.
- Reset: state IDLE. All outputs 0, counters 0. `we_d` (registered we_logic) = 1.
- Reset mid-burst: `loc_gnt` drops the next cycle, no `loc_abort` pulse, any read in flight is discarded.
- Definitions:
  - fall = (we_d==1 && we_logic==0), sampled at an edge.
  - xfer = (state==LOC_ACC && loc_req && mcu_idle && !fall).
- fall has top priority in every state. At that edge:
  - `ram_en`/`ram_we` <= 1, `ram_addr` <= `emif_addr`, `ram_wdata` <= `emif_data` (RAM write visible 1 cycle later).
  - `mcu_wr_cnt` += 1; state <= MCU_WR.
  - If the state was LOC_ACC: `loc_abort` <= 1 and `preempt_cnt` += 1 (saturating).
- On an xfer edge: `ram_en` <= 1, `ram_we` <= `loc_we`, `ram_addr`/`ram_wdata` <= `loc_addr`/`loc_wdata`. Burst counter += 1.
- At any edge with neither fall nor xfer: `ram_en`/`ram_we` <= 0. `ram_addr`/`ram_wdata` hold their values.
- `loc_rvalid` is high the cycle after a local read is issued on `ram_*` (ram_en=1, ram_we=0, local source).
  - A read issued in the cycle before an abort still returns its `loc_rvalid`.
- State transitions (evaluated when fall=0):
  - IDLE -> GUARD when `mcu_idle` && `loc_req`; guard counter <= 0.
  - GUARD:
    - If `mcu_idle`==0 or `loc_req`==0 -> IDLE, no pulse.
    - Else if counter == GUARD-1 -> LOC_ACC, burst counter <= 0.
    - Else counter += 1.
    - Net effect: `loc_gnt` rises GUARD+1 cycles after `loc_req` is first sampled.
  - LOC_ACC:
    - `mcu_idle`==0 -> IDLE, `loc_abort` pulse, `preempt_cnt` += 1; no transfer that edge.
    - `loc_req`==0 -> IDLE, `loc_done` pulse.
    - xfer that is the LOC_MAX-th of the burst -> IDLE, `loc_done` pulse. The requester re-arbitrates through GUARD.
  - MCU_WR -> IDLE when `we_logic`==1 is sampled.
  - fall in GUARD -> MCU_WR, no abort pulse.
- Simultaneous events:
  - fall and `loc_req` drop at the same edge: abort wins; no done pulse.
  - `mcu_idle` drop and last transfer at the same edge: abort wins; transfer not issued.
- `loc_done` and `loc_abort` are never high in the same cycle.
- Each fall produces exactly one RAM write.
- Guarantee: a local access is never on `ram_*` in the cycle after a fall edge.
- Implementation target: registered outputs, 4-state FSM, ~200 lines.

Test Plan:
- Reset: hold `rst`=1 for 3 cycles with `we_logic`=1 -> all outputs 0, state IDLE; release -> no `ram_en` while `we_logic` stays 1.
- MCU write: drive `we_logic` low for 6 cycles with addr 0x12, data 0xBEEF -> exactly one cycle with `ram_en`=`ram_we`=1, addr 0x12, data 0xBEEF, 1 cycle after the fall; `mcu_wr_cnt`=1.
- Local burst: `mcu_idle`=1, `loc_req` held for 3 reads at 0x01..0x03, GUARD=4 -> `loc_gnt` rises 5 cycles after `loc_req`; 3 `loc_rvalid` pulses; `loc_done` pulse after `loc_req` drops.
- LOC_MAX cap: `loc_req` held for 20 cycles, LOC_MAX=8 -> 8 transfers, `loc_done` pulse, gap of at least GUARD+1 cycles, then a second grant.
- Pre-emption: `we_logic` falls during the 3rd transfer of a burst -> `loc_abort` pulse, `loc_gnt` low; MCU write on `ram_*` next cycle; `preempt_cnt`=1; earlier reads still return `loc_rvalid`.
- Corner cases:
  - `mcu_idle` drops in GUARD at count 2 -> no grant, no pulse.
  - `mcu_wr_cnt` preset path: 65536 writes -> wraps to 0.
  - 300 aborts -> `preempt_cnt`=0xFF.

Source files
------------

// File: rtl/emif_bus_arbiter_if.sv
// Bundle of the EMIF, local-requester and RAM signals handled by the arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the EMIF sync block, the local requester and the RAM.
interface emif_bus_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          we_logic;
   logic          mcu_idle;
   logic [AW-1:0] emif_addr;
   logic [DW-1:0] emif_data;
   logic          loc_req;
   logic          loc_we;
   logic [AW-1:0] loc_addr;
   logic [DW-1:0] loc_wdata;
   logic          loc_gnt;
   logic [DW-1:0] loc_rdata;
   logic          loc_rvalid;
   logic          loc_done;
   logic          loc_abort;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic [15:0]   mcu_wr_cnt;
   logic [7:0]    preempt_cnt;

   modport slave (
      input  we_logic, mcu_idle, emif_addr, emif_data,
      input  loc_req, loc_we, loc_addr, loc_wdata, ram_rdata,
      output loc_gnt, loc_rdata, loc_rvalid, loc_done, loc_abort,
      output ram_en, ram_we, ram_addr, ram_wdata, mcu_wr_cnt, preempt_cnt
   );

   modport master (
      output we_logic, mcu_idle, emif_addr, emif_data,
      output loc_req, loc_we, loc_addr, loc_wdata, ram_rdata,
      input  loc_gnt, loc_rdata, loc_rvalid, loc_done, loc_abort,
      input  ram_en, ram_we, ram_addr, ram_wdata, mcu_wr_cnt, preempt_cnt
   );
endinterface

// File: rtl/emif_bus_arbiter.sv
// Arbiter that shares one single-port RAM between MCU EMIF writes and a local
// FPGA requester. The MCU always wins. A local burst is granted only after
// mcu_idle and loc_req have held through a guard interval. The burst is
// pre-empted as soon as the MCU becomes active.
module emif_bus_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 16,
   parameter int GUARD   = 4,
   parameter int LOC_MAX = 8
) (
   input  logic                clk,
   input  logic                rst,
   emif_bus_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_GUARD, S_LOC_ACC, S_MCU_WR} state_t;

   localparam int GW = (GUARD > 1)   ? $clog2(GUARD)   : 1;
   localparam int BW = (LOC_MAX > 1) ? $clog2(LOC_MAX) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(LOC_MAX - 1);

   state_t        state_q, state_d;
   logic [GW-1:0] guard_cnt_q, guard_cnt_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic          we_dly_q, we_dly_d;
   logic          ram_en_q, ram_en_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic          ram_loc_q, ram_loc_d;     // current ram_* access came from the local side
   logic          rvalid_q, rvalid_d;
   logic          done_q, done_d;
   logic          abort_q, abort_d;
   logic          gnt_q, gnt_d;
   logic [15:0]   mcu_wr_cnt_q, mcu_wr_cnt_d;
   logic [7:0]    preempt_cnt_q, preempt_cnt_d;

   logic fall;
   logic xfer;

   // A falling MCU write strobe overrides everything else. A local transfer
   // is issued only while granted, requested and the MCU stays idle.
   assign fall = we_dly_q & ~bus.we_logic;
   assign xfer = (state_q == S_LOC_ACC) & bus.loc_req & bus.mcu_idle & ~fall;

   // State register and all output/counter flops, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         guard_cnt_q   <= '0;
         burst_cnt_q   <= '0;
         we_dly_q      <= 1'b1;
         ram_en_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_loc_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         done_q        <= 1'b0;
         abort_q       <= 1'b0;
         gnt_q         <= 1'b0;
         mcu_wr_cnt_q  <= '0;
         preempt_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         guard_cnt_q   <= guard_cnt_d;
         burst_cnt_q   <= burst_cnt_d;
         we_dly_q      <= we_dly_d;
         ram_en_q      <= ram_en_d;
         ram_we_q      <= ram_we_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         ram_loc_q     <= ram_loc_d;
         rvalid_q      <= rvalid_d;
         done_q        <= done_d;
         abort_q       <= abort_d;
         gnt_q         <= gnt_d;
         mcu_wr_cnt_q  <= mcu_wr_cnt_d;
         preempt_cnt_q <= preempt_cnt_d;
      end
   end

   // Next-state logic with guard/burst counters and done/abort events
   always_comb begin
      state_d     = state_q;
      guard_cnt_d = guard_cnt_q;
      burst_cnt_d = burst_cnt_q;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      if (fall) begin
         state_d = S_MCU_WR;
         abort_d = (state_q == S_LOC_ACC);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.mcu_idle && bus.loc_req) begin
                  state_d     = S_GUARD;
                  guard_cnt_d = '0;
               end
            end
            S_GUARD: begin
               if (!bus.mcu_idle || !bus.loc_req) begin
                  state_d = S_IDLE;
               end else if (guard_cnt_q == GUARD_LAST) begin
                  state_d     = S_LOC_ACC;
                  burst_cnt_d = '0;
               end else begin
                  guard_cnt_d = guard_cnt_q + 1'b1;
               end
            end
            S_LOC_ACC: begin
               if (!bus.mcu_idle) begin
                  // MCU leaving idle pre-empts; that edge carries no transfer
                  state_d = S_IDLE;
                  abort_d = 1'b1;
               end else if (!bus.loc_req) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else if (burst_cnt_q == BURST_LAST) begin
                  // Last allowed transfer: the requester has to re-arbitrate
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  burst_cnt_d = burst_cnt_q + 1'b1;
               end
            end
            S_MCU_WR: begin
               if (bus.we_logic) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic: RAM port mux, read-valid tracking, grant and counters
   always_comb begin
      we_dly_d      = bus.we_logic;
      ram_en_d      = 1'b0;
      ram_we_d      = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;
      ram_loc_d     = 1'b0;
      rvalid_d      = ram_en_q & ~ram_we_q & ram_loc_q;
      gnt_d         = (state_d == S_LOC_ACC);
      mcu_wr_cnt_d  = mcu_wr_cnt_q;
      preempt_cnt_d = preempt_cnt_q;
      if (fall) begin
         ram_en_d     = 1'b1;
         ram_we_d     = 1'b1;
         ram_addr_d   = bus.emif_addr;
         ram_wdata_d  = bus.emif_data;
         mcu_wr_cnt_d = mcu_wr_cnt_q + 16'd1;
      end else if (xfer) begin
         ram_en_d    = 1'b1;
         ram_we_d    = bus.loc_we;
         ram_addr_d  = bus.loc_addr;
         ram_wdata_d = bus.loc_wdata;
         ram_loc_d   = 1'b1;
      end
      if (abort_d && (preempt_cnt_q != 8'hFF)) begin
         preempt_cnt_d = preempt_cnt_q + 8'd1;
      end
   end

   assign bus.loc_gnt     = gnt_q;
   assign bus.loc_rdata   = bus.ram_rdata;
   assign bus.loc_rvalid  = rvalid_q;
   assign bus.loc_done    = done_q;
   assign bus.loc_abort   = abort_q;
   assign bus.ram_en      = ram_en_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.mcu_wr_cnt  = mcu_wr_cnt_q;
   assign bus.preempt_cnt = preempt_cnt_q;

endmodule

// File: tb/tb_emif_bus_arbiter.sv
// Directed testbench for emif_bus_arbiter (GUARD=4, LOC_MAX=8).
module tb_emif_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   emif_bus_arbiter_if #(.AW(8), .DW(16)) bus ();

   emif_bus_arbiter #(.AW(8), .DW(16), .GUARD(4), .LOC_MAX(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM stand-in: a read of address a returns 16'hA500 | a one cycle later
   always @(posedge clk) begin
      if (rst) bus.ram_rdata <= 16'h0000;
      else if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= {8'hA5, bus.ram_addr};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for loc_gnt. Returns the step index at which it rose, or 0 if it never did.
   task automatic wait_gnt(output int at);
      at = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (bus.loc_gnt === 1'b1) begin
            at = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int en_seen;
      $display("[TB] reset: 3 cycles, then idle with we_logic high");
      rst = 1'b1;
      bus.we_logic = 1'b1; bus.mcu_idle = 1'b0; bus.emif_addr = '0; bus.emif_data = '0;
      bus.loc_req = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = '0; bus.loc_wdata = '0;
      repeat (3) step();
      tests++;
      if ({bus.loc_gnt, bus.loc_rvalid, bus.loc_done, bus.loc_abort, bus.ram_en, bus.ram_we} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b, expected 000000",
                  {bus.loc_gnt, bus.loc_rvalid, bus.loc_done, bus.loc_abort, bus.ram_en, bus.ram_we});
      end
      tests++;
      if (bus.ram_addr !== 8'h00 || bus.ram_wdata !== 16'h0000) begin
         fails++;
         $display("FAIL reset_ram_bus: got addr=%h data=%h, expected 00/0000", bus.ram_addr, bus.ram_wdata);
      end
      tests++;
      if (bus.mcu_wr_cnt !== 16'h0000 || bus.preempt_cnt !== 8'h00) begin
         fails++;
         $display("FAIL reset_counters: got wr=%h pre=%h, expected 0/0", bus.mcu_wr_cnt, bus.preempt_cnt);
      end
      rst = 1'b0;
      en_seen = 0;
      repeat (5) begin
         step();
         if (bus.ram_en === 1'b1) en_seen++;
      end
      tests++;
      if (en_seen !== 0) begin
         fails++;
         $display("FAIL reset_release_ram_en: got %0d enable cycles, expected 0", en_seen);
      end
   endtask

   task automatic test_mcu_write();
      int en_cnt;
      $display("[TB] mcu write addr=12 data=BEEF");
      bus.emif_addr = 8'h12; bus.emif_data = 16'hBEEF; bus.we_logic = 1'b0;
      step();
      tests++;
      if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1) begin
         fails++;
         $display("FAIL mcu_wr_enables: got en=%b we=%b, expected 1/1", bus.ram_en, bus.ram_we);
      end
      tests++;
      if (bus.ram_addr !== 8'h12 || bus.ram_wdata !== 16'hBEEF) begin
         fails++;
         $display("FAIL mcu_wr_bus: got addr=%h data=%h, expected 12/BEEF", bus.ram_addr, bus.ram_wdata);
      end
      tests++;
      if (bus.mcu_wr_cnt !== 16'd1) begin
         fails++;
         $display("FAIL mcu_wr_cnt: got %0d, expected 1", bus.mcu_wr_cnt);
      end
      en_cnt = (bus.ram_en === 1'b1) ? 1 : 0;
      repeat (5) begin
         step();
         if (bus.ram_en === 1'b1) en_cnt++;
      end
      bus.we_logic = 1'b1; bus.emif_addr = 8'h55; bus.emif_data = 16'h0000;
      repeat (3) begin
         step();
         if (bus.ram_en === 1'b1) en_cnt++;
      end
      tests++;
      if (en_cnt !== 1) begin
         fails++;
         $display("FAIL mcu_wr_single: got %0d write cycles, expected 1", en_cnt);
      end
      tests++;
      if (bus.ram_addr !== 8'h12 || bus.mcu_wr_cnt !== 16'd1) begin
         fails++;
         $display("FAIL mcu_wr_hold: got addr=%h cnt=%0d, expected 12/1", bus.ram_addr, bus.mcu_wr_cnt);
      end
   endtask

   task automatic test_local_burst();
      int at;
      $display("[TB] local burst: 3 reads at 01..03");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h01;
      wait_gnt(at);
      tests++;
      if (at !== 5) begin
         fails++;
         $display("FAIL burst_gnt_latency: got %0d, expected 5", at);
      end
      step();
      tests++;
      if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h01) begin
         fails++;
         $display("FAIL burst_rd1: got en=%b we=%b addr=%h, expected 1/0/01", bus.ram_en, bus.ram_we, bus.ram_addr);
      end
      bus.loc_addr = 8'h02;
      step();
      tests++;
      if (bus.ram_addr !== 8'h02 || bus.loc_rvalid !== 1'b1 || bus.loc_rdata !== 16'hA501) begin
         fails++;
         $display("FAIL burst_rd2: got addr=%h rv=%b rd=%h, expected 02/1/A501", bus.ram_addr, bus.loc_rvalid, bus.loc_rdata);
      end
      bus.loc_addr = 8'h03;
      step();
      tests++;
      if (bus.ram_addr !== 8'h03 || bus.loc_rvalid !== 1'b1 || bus.loc_rdata !== 16'hA502) begin
         fails++;
         $display("FAIL burst_rd3: got addr=%h rv=%b rd=%h, expected 03/1/A502", bus.ram_addr, bus.loc_rvalid, bus.loc_rdata);
      end
      bus.loc_req = 1'b0;
      step();
      tests++;
      if (bus.ram_en !== 1'b0 || bus.loc_done !== 1'b1 || bus.loc_gnt !== 1'b0 || bus.loc_abort !== 1'b0) begin
         fails++;
         $display("FAIL burst_done: got en=%b done=%b gnt=%b abort=%b, expected 0/1/0/0",
                  bus.ram_en, bus.loc_done, bus.loc_gnt, bus.loc_abort);
      end
      tests++;
      if (bus.loc_rvalid !== 1'b1 || bus.loc_rdata !== 16'hA503) begin
         fails++;
         $display("FAIL burst_rd3_data: got rv=%b rd=%h, expected 1/A503", bus.loc_rvalid, bus.loc_rdata);
      end
      bus.mcu_idle = 1'b0;
      step();
      tests++;
      if (bus.loc_done !== 1'b0 || bus.loc_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL burst_quiet: got done=%b rv=%b, expected 0/0", bus.loc_done, bus.loc_rvalid);
      end
   endtask

   task automatic test_loc_max();
      int xfers, xfers_first, done_step, rise1, rise2, fall_step;
      logic prev;
      $display("[TB] loc_max: loc_req held 20 cycles, local writes to 40");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1; bus.loc_we = 1'b1; bus.loc_addr = 8'h40; bus.loc_wdata = 16'h1000;
      xfers = 0; xfers_first = 0; done_step = 0; rise1 = 0; rise2 = 0; fall_step = 0; prev = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1 && bus.ram_addr === 8'h40) xfers++;
         if (bus.loc_done === 1'b1 && done_step == 0) begin
            done_step = i;
            xfers_first = xfers;
         end
         if (bus.loc_gnt === 1'b1 && !prev) begin
            if (rise1 == 0) rise1 = i;
            else if (rise2 == 0) rise2 = i;
         end
         if (bus.loc_gnt === 1'b0 && prev && fall_step == 0) fall_step = i;
         prev = bus.loc_gnt;
      end
      tests++;
      if (xfers_first !== 8 || done_step !== 13) begin
         fails++;
         $display("FAIL loc_max_cap: got %0d xfers, done at %0d, expected 8 at 13", xfers_first, done_step);
      end
      tests++;
      if (rise1 !== 5 || fall_step !== 13 || rise2 !== 18) begin
         fails++;
         $display("FAIL loc_max_grants: got rise %0d fall %0d rise %0d, expected 5/13/18", rise1, fall_step, rise2);
      end
      tests++;
      if (rise2 - fall_step < 5) begin
         fails++;
         $display("FAIL loc_max_gap: got %0d, expected >= 5", rise2 - fall_step);
      end
      tests++;
      if (xfers !== 10) begin
         fails++;
         $display("FAIL loc_max_total: got %0d, expected 10", xfers);
      end
      bus.loc_req = 1'b0;
      step();
      tests++;
      if (bus.loc_done !== 1'b1 || bus.loc_abort !== 1'b0) begin
         fails++;
         $display("FAIL loc_max_done2: got done=%b abort=%b, expected 1/0", bus.loc_done, bus.loc_abort);
      end
      bus.mcu_idle = 1'b0;
      step();
   endtask

   task automatic test_preempt();
      int at;
      $display("[TB] preempt: we_logic falls on 3rd read, mcu addr=77 data=1234");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h21;
      wait_gnt(at);
      tests++;
      if (at !== 5) begin
         fails++;
         $display("FAIL preempt_gnt: got %0d, expected 5", at);
      end
      step();
      bus.loc_addr = 8'h22;
      step();
      tests++;
      if (bus.loc_rvalid !== 1'b1 || bus.loc_rdata !== 16'hA521) begin
         fails++;
         $display("FAIL preempt_rd1: got rv=%b rd=%h, expected 1/A521", bus.loc_rvalid, bus.loc_rdata);
      end
      bus.loc_addr = 8'h23; bus.we_logic = 1'b0; bus.emif_addr = 8'h77; bus.emif_data = 16'h1234;
      step();
      tests++;
      if (bus.loc_abort !== 1'b1 || bus.loc_done !== 1'b0 || bus.loc_gnt !== 1'b0) begin
         fails++;
         $display("FAIL preempt_pulse: got abort=%b done=%b gnt=%b, expected 1/0/0", bus.loc_abort, bus.loc_done, bus.loc_gnt);
      end
      tests++;
      if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h77 || bus.ram_wdata !== 16'h1234) begin
         fails++;
         $display("FAIL preempt_mcu_bus: got en=%b we=%b addr=%h data=%h, expected 1/1/77/1234",
                  bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      tests++;
      if (bus.preempt_cnt !== 8'd1 || bus.mcu_wr_cnt !== 16'd2) begin
         fails++;
         $display("FAIL preempt_counts: got pre=%0d wr=%0d, expected 1/2", bus.preempt_cnt, bus.mcu_wr_cnt);
      end
      tests++;
      if (bus.loc_rvalid !== 1'b1 || bus.loc_rdata !== 16'hA522) begin
         fails++;
         $display("FAIL preempt_inflight_rd: got rv=%b rd=%h, expected 1/A522", bus.loc_rvalid, bus.loc_rdata);
      end
      bus.mcu_idle = 1'b0; bus.loc_req = 1'b0;
      step();
      tests++;
      if (bus.loc_abort !== 1'b0 || bus.loc_rvalid !== 1'b0 || bus.ram_en !== 1'b0) begin
         fails++;
         $display("FAIL preempt_after: got abort=%b rv=%b en=%b, expected 0/0/0", bus.loc_abort, bus.loc_rvalid, bus.ram_en);
      end
      repeat (4) step();
      bus.we_logic = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_guard_drop();
      int pulses, gnts;
      $display("[TB] guard drop: mcu_idle low at guard count 2");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1;
      repeat (3) step();
      bus.mcu_idle = 1'b0;
      pulses = 0; gnts = 0;
      repeat (8) begin
         step();
         if (bus.loc_done === 1'b1 || bus.loc_abort === 1'b1) pulses++;
         if (bus.loc_gnt === 1'b1) gnts++;
      end
      tests++;
      if (gnts !== 0 || pulses !== 0) begin
         fails++;
         $display("FAIL guard_drop: got %0d grant cycles %0d pulses, expected 0/0", gnts, pulses);
      end
      tests++;
      if (bus.preempt_cnt !== 8'd1) begin
         fails++;
         $display("FAIL guard_drop_precnt: got %0d, expected 1", bus.preempt_cnt);
      end
      bus.loc_req = 1'b0;
      step();
   endtask

   task automatic test_simultaneous();
      int at;
      $display("[TB] simultaneous: fall with loc_req drop, addr=88");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h30;
      wait_gnt(at);
      step();
      bus.we_logic = 1'b0; bus.loc_req = 1'b0; bus.emif_addr = 8'h88;
      step();
      tests++;
      if (at !== 5 || bus.loc_abort !== 1'b1 || bus.loc_done !== 1'b0) begin
         fails++;
         $display("FAIL simul_fall_req: got gnt_at=%0d abort=%b done=%b, expected 5/1/0", at, bus.loc_abort, bus.loc_done);
      end
      tests++;
      if (bus.ram_addr !== 8'h88 || bus.preempt_cnt !== 8'd2) begin
         fails++;
         $display("FAIL simul_fall_bus: got addr=%h pre=%0d, expected 88/2", bus.ram_addr, bus.preempt_cnt);
      end
      bus.mcu_idle = 1'b0;
      repeat (4) step();
      bus.we_logic = 1'b1;
      repeat (2) step();
      $display("[TB] simultaneous: mcu_idle drop on 8th transfer, addr=31");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1; bus.loc_addr = 8'h31;
      wait_gnt(at);
      repeat (7) step();
      bus.mcu_idle = 1'b0;
      step();
      tests++;
      if (bus.loc_abort !== 1'b1 || bus.loc_done !== 1'b0 || bus.ram_en !== 1'b0) begin
         fails++;
         $display("FAIL simul_idle_last: got abort=%b done=%b en=%b, expected 1/0/0", bus.loc_abort, bus.loc_done, bus.ram_en);
      end
      tests++;
      if (bus.preempt_cnt !== 8'd3) begin
         fails++;
         $display("FAIL simul_idle_precnt: got %0d, expected 3", bus.preempt_cnt);
      end
      bus.loc_req = 1'b0;
      step();
   endtask

   task automatic test_wr_wrap();
      $display("[TB] mcu_wr_cnt wrap: preset FFFE, two writes");
      dut.mcu_wr_cnt_q = 16'hFFFE;
      bus.emif_addr = 8'h01; bus.we_logic = 1'b0;
      step();
      tests++;
      if (bus.mcu_wr_cnt !== 16'hFFFF) begin
         fails++;
         $display("FAIL wr_wrap_ffff: got %h, expected FFFF", bus.mcu_wr_cnt);
      end
      bus.we_logic = 1'b1;
      repeat (2) step();
      bus.we_logic = 1'b0;
      step();
      tests++;
      if (bus.mcu_wr_cnt !== 16'h0000) begin
         fails++;
         $display("FAIL wr_wrap_zero: got %h, expected 0000", bus.mcu_wr_cnt);
      end
      bus.we_logic = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_preempt_saturate();
      int aborts;
      logic got;
      $display("[TB] preempt_cnt saturation: 300 aborts via mcu_idle drop");
      aborts = 0;
      for (int k = 0; k < 300; k++) begin
         bus.mcu_idle = 1'b1; bus.loc_req = 1'b1;
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = bus.loc_gnt;
         end
         if (!got) begin
            tests++;
            fails++;
            $display("FAIL sat_gnt_timeout: got no grant in iteration %0d, expected grant", k);
         end
         bus.mcu_idle = 1'b0;
         step();
         if (bus.loc_abort === 1'b1) aborts++;
         bus.loc_req = 1'b0;
         step();
         if (k == 250) begin
            tests++;
            if (bus.preempt_cnt !== 8'hFE) begin
               fails++;
               $display("FAIL sat_precnt_fe: got %h, expected FE", bus.preempt_cnt);
            end
         end
      end
      tests++;
      if (aborts !== 300) begin
         fails++;
         $display("FAIL sat_abort_pulses: got %0d, expected 300", aborts);
      end
      tests++;
      if (bus.preempt_cnt !== 8'hFF) begin
         fails++;
         $display("FAIL sat_precnt_ff: got %h, expected FF", bus.preempt_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      int at;
      $display("[TB] reset mid-burst with read in flight");
      bus.mcu_idle = 1'b1; bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h05;
      wait_gnt(at);
      step();
      rst = 1'b1;
      step();
      tests++;
      if (bus.loc_gnt !== 1'b0 || bus.loc_abort !== 1'b0 || bus.loc_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got gnt=%b abort=%b rv=%b, expected 0/0/0", bus.loc_gnt, bus.loc_abort, bus.loc_rvalid);
      end
      tests++;
      if (bus.preempt_cnt !== 8'h00 || bus.mcu_wr_cnt !== 16'h0000) begin
         fails++;
         $display("FAIL reset_mid_cnts: got pre=%h wr=%h, expected 00/0000", bus.preempt_cnt, bus.mcu_wr_cnt);
      end
      rst = 1'b0;
      bus.mcu_idle = 1'b0; bus.loc_req = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_mcu_write();
      test_local_burst();
      test_loc_max();
      test_preempt();
      test_guard_drop();
      test_simultaneous();
      test_wr_wrap();
      test_preempt_saturate();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
